muldiv_sequencer: RTL and testbench
===================================

Name: muldiv_sequencer

Overview:
- Iterative multiply/divide engine and its sequencing FSM, instantiated beside the multicycle datapath.
- The main controller issues one op with a Start pulse and holds its FSM in a wait state while Busy is high.
- Executes MUL, UMULL, SMULL, UDIV and SDIV on operands read from the register file.
- Returns a 64-bit result split into Lo/Hi halves for write-back.

Parameters:
- WIDTH, 32, operand width in bits; results are 2*WIDTH bits.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-high reset.
- Start  in  1  request pulse; sampled only in IDLE.
- Op  in  3  operation select, captured at Start:
  - Op[2]: 1=divide, 0=multiply.
  - Op[1]: 1=signed.
  - Op[0]: 1=long multiply, ignored for divide.
- SrcA  in  WIDTH  multiplicand or dividend; captured at Start.
- SrcB  in  WIDTH  multiplier or divisor; captured at Start.
- Busy  out  1  high from the cycle after Start is accepted until Done; used as the controller stall.
- Done  out  1  one-cycle pulse when results are valid.
- ResultLo  out  WIDTH  product[WIDTH-1:0] or quotient.
- ResultHi  out  WIDTH  product[2*WIDTH-1:WIDTH] or remainder.
- DivByZero  out  1  pulses together with Done when a divide had SrcB==0.

Behaviour:
- Reset: state=IDLE; Busy, Done and DivByZero are 0; ResultLo and ResultHi are 0. Reset mid-operation aborts immediately; no Done is emitted for the aborted op.
- States and transitions:
  - IDLE -> PREP on Start. Captures Op, SrcA and SrcB.
  - PREP (1 cycle): for signed ops, takes absolute values of both operands and records sign flags. Result sign for multiply and quotient = signA^signB; remainder sign = signA. Clears the accumulator and sets the counter to WIDTH.
  - PREP -> DONE directly for a divide with divisor==0.
  - PREP -> ITER otherwise.
  - ITER: WIDTH cycles, one bit per cycle; the counter decrements each cycle and ITER exits when it reaches 0.
    - Multiply: shift-add. If the multiplier LSB is 1, add the multiplicand into the upper accumulator, then shift {acc,mplr} right by 1 with the carry shifted in.
    - Divide: restoring. Shift {rem,quot} left by 1, trial-subtract the divisor from rem; if no borrow, keep the difference and set quot[0]=1.
  - FIX (1 cycle): applies two's-complement negation per the sign flags. A multiply negates the full 2*WIDTH product; a divide negates quotient and remainder independently.
  - DONE (1 cycle): Done=1, results registered; next state IDLE.
- Latency: Start accepted at cycle 0 gives Done at cycle WIDTH+3 (35 for WIDTH=32). Divide-by-zero gives Done at cycle 2.
- Busy=1 in PREP, ITER and FIX; Busy=0 in DONE and IDLE. The controller may therefore issue a new Start in the cycle after Done.
- Start while not IDLE is ignored. Op and Src changes after capture have no effect.
- ResultLo/ResultHi hold their values until the next DONE or reset.
- Non-long MUL: ResultLo = low half, identical for signed and unsigned. ResultHi = unsigned high half; the controller ignores it.
- Divide by zero: ResultLo=0, ResultHi=SrcA (raw, unsigned form), DivByZero=1 for the Done cycle.
- SDIV overflow: 0x80000000 / 0xFFFFFFFF gives ResultLo=0x80000000 (wraps), ResultHi=0, DivByZero=0.
- Negating zero yields zero. A zero remainder is never given a negative sign.

Optional Feature:
- Macro: MULDIV_EARLY_TERM_EN.
- Defined:
  - A multiply leaves ITER early when the remaining unshifted multiplier bits are all zero, after at least 1 iteration.
  - The accumulator is right-aligned in FIX by the remaining count using a barrel shift.
  - Multiply latency becomes variable: minimum 4 cycles Start->Done, maximum WIDTH+3.
  - Divide timing is unchanged.
- Undefined: fixed WIDTH+3 latency for all non-zero-divisor ops, and no barrel shifter is synthesised.

Test Plan:
- UMULL: SrcA=0xFFFFFFFF, SrcB=0xFFFFFFFF -> Hi=0xFFFFFFFE, Lo=0x00000001; Done exactly 35 cycles after Start (macro undefined).
- SMULL: SrcA=0xFFFFFFFE (-2), SrcB=0x00000003 -> Hi=0xFFFFFFFF, Lo=0xFFFFFFFA; MUL 7*6 -> Lo=0x0000002A.
- SDIV: -7 / 2 -> Lo=0xFFFFFFFD, Hi=0xFFFFFFFF. SDIV 0x80000000 / 0xFFFFFFFF -> Lo=0x80000000, Hi=0.
- UDIV: 100 / 0 -> Done 2 cycles after Start, DivByZero=1, Lo=0, Hi=100. Next UDIV 100/7 -> Lo=14, Hi=2, DivByZero=0.
- Back-to-back and abort:
  - A Start pulsed during Busy is ignored and results match the first op.
  - A Start in the cycle after Done is accepted.
  - reset asserted at iteration 10 -> IDLE, all outputs 0, no Done.
- MULDIV_EARLY_TERM_EN defined: UMULL 0x12345678 * 0x00000003 -> correct product (Hi=0, Lo=0x369D0368), Done within 5 cycles; all other tests still pass.

Source files
------------

// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: iterative shift-add multiply / restoring divide engine with its sequencing FSM.
// Define MULDIV_EARLY_TERM_EN to let multiplies leave ITER once the remaining multiplier bits are zero.
module muldiv_sequencer #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             Start,
  input  logic [2:0]       Op,
  input  logic [WIDTH-1:0] SrcA,
  input  logic [WIDTH-1:0] SrcB,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] ResultLo,
  output logic [WIDTH-1:0] ResultHi,
  output logic             DivByZero
);
  typedef enum logic [2:0] {IDLE, PREP, ITER, FIX, DONE} state_t;
  state_t state, state_n;
  logic [2:0] op;
  logic [WIDTH-1:0] a, b, acc, lo, abs_a, abs_b, diff, quo, rem;
  logic [WIDTH:0] sum, rem_sh;
  logic [2*WIDTH-1:0] prod, prod_s;
  logic [CNT_W-1:0] cnt;
  logic is_div, is_sgn, sa, sb, fits, last, dz, neg_q, neg_r, zero_div;
  // plain MUL is treated as unsigned so its high half is the unsigned one
  assign is_div = op[2];
  assign is_sgn = op[1] & (op[2] | op[0]);
  assign sa = is_sgn & a[WIDTH-1];
  assign sb = is_sgn & b[WIDTH-1];
  assign abs_a = sa ? -a : a;
  assign abs_b = sb ? -b : b;
  assign zero_div = is_div && b == '0;
  assign sum = {1'b0, acc} + (lo[0] ? {1'b0, b} : '0);
  assign rem_sh = {acc, lo[WIDTH-1]};
  assign fits = rem_sh >= {1'b0, b};
  assign diff = rem_sh[WIDTH-1:0] - b;
`ifdef MULDIV_EARLY_TERM_EN
  // low cnt bits of lo still hold unconsumed multiplier bits; the rest is product
  assign last = cnt == CNT_W'(1) ||
                (!is_div && ((lo >> 1) & ~({WIDTH{1'b1}} << (cnt - CNT_W'(1)))) == '0);
  assign prod_s = {acc, lo} >> cnt;
`else
  assign last = cnt == CNT_W'(1);
  assign prod_s = {acc, lo};
`endif
  assign prod = neg_q ? -prod_s : prod_s;
  assign quo = neg_q ? -lo : lo;
  assign rem = neg_r ? -acc : acc;
  assign Busy = state == PREP || state == ITER || state == FIX;
  assign Done = state == DONE;
  assign DivByZero = Done & dz;
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else state <= state_n;
  end
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = Start ? PREP : IDLE;
      PREP:    state_n = zero_div ? DONE : ITER;
      ITER:    state_n = last ? FIX : ITER;
      FIX:     state_n = DONE;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      dz <= 1'b0;
      ResultLo <= '0;
      ResultHi <= '0;
    end else begin
      if (state == IDLE && Start) begin
        op <= Op;
        a <= SrcA;
        b <= SrcB;
      end
      if (state == PREP) begin
        neg_q <= sa ^ sb;
        neg_r <= sa;
        acc <= '0;
        cnt <= CNT_W'(WIDTH);
        lo <= is_div ? abs_a : abs_b;
        b <= is_div ? abs_b : abs_a;
        dz <= zero_div;
        if (zero_div) begin
          ResultLo <= '0;
          ResultHi <= a;
        end
      end
      if (state == ITER) begin
        cnt <= cnt - CNT_W'(1);
        acc <= is_div ? (fits ? diff : rem_sh[WIDTH-1:0]) : sum[WIDTH:1];
        lo <= is_div ? {lo[WIDTH-2:0], fits} : {sum[0], lo[WIDTH-1:1]};
      end
      if (state == FIX) begin
        ResultLo <= is_div ? quo : prod[WIDTH-1:0];
        ResultHi <= is_div ? rem : prod[2*WIDTH-1:WIDTH];
      end
    end
  end
endmodule

// File: tb/tb_muldiv_sequencer.sv
// tb_muldiv_sequencer: directed vectors with hand-computed results for the multiply/divide sequencer.
module tb_muldiv_sequencer;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic Start = 1'b0;
  logic [2:0] Op = '0;
  logic [31:0] SrcA = '0, SrcB = '0;
  logic Busy, Done, DivByZero;
  logic [31:0] ResultLo, ResultHi;
  int n_chk = 0, n_fail = 0, lat = 0;
  logic seen;

  localparam logic [2:0] MUL = 3'b000, SMUL = 3'b010, UMULL = 3'b001, SMULL = 3'b011;
  localparam logic [2:0] UDIV = 3'b100, SDIV = 3'b110;

  muldiv_sequencer dut (
    .clk(clk), .reset(reset), .Start(Start), .Op(Op), .SrcA(SrcA), .SrcB(SrcB),
    .Busy(Busy), .Done(Done), .ResultLo(ResultLo), .ResultHi(ResultHi), .DivByZero(DivByZero)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // pulses Start in an IDLE cycle; returns sampled in the Done cycle with lat = cycles since accept
  task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y, input int poke);
    @(posedge clk); #1;
    Op = o; SrcA = x; SrcB = y; Start = 1'b1;
    @(posedge clk); #1;
    Start = 1'b0;
    lat = 1;
    while (!Done && lat < 100) begin
      Start = (lat == poke);
      if (lat == poke) begin
        Op = UMULL; SrcA = '1; SrcB = '1;
      end
      @(posedge clk); #1;
      lat++;
    end
    Start = 1'b0;
    if (!Done) check("timeout", 64'(lat), 64'(0));
  endtask

  task automatic result(input string tag, input logic [31:0] hi, input logic [31:0] lo, input logic z);
    check(tag, {ResultHi, ResultLo}, {hi, lo});
    check({tag, "_dz"}, 64'(DivByZero), 64'(z));
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    check("reset_out", {29'd0, Busy, Done, DivByZero, ResultHi, ResultLo}, 64'd0);

    issue(UMULL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    result("umull_ff", 32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
`ifndef MULDIV_EARLY_TERM_EN
    check("umull_lat", 64'(lat), 64'd35);
`endif
    @(posedge clk); #1;
    check("done_pulse", {62'd0, Done, Busy}, 64'd0);

    issue(SMULL, 32'hFFFF_FFFE, 32'h0000_0003, 0);
    result("smull", 32'hFFFF_FFFF, 32'hFFFF_FFFA, 1'b0);
    issue(MUL, 32'd7, 32'd6, 0);
    result("mul_7x6", 32'd0, 32'h0000_002A, 1'b0);
    issue(SMUL, 32'hFFFF_FFFE, 32'h0000_0003, 0);
    result("smul_hi_unsigned", 32'h0000_0002, 32'hFFFF_FFFA, 1'b0);

    issue(SDIV, 32'hFFFF_FFF9, 32'd2, 0);
    result("sdiv_m7_2", 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
    check("sdiv_lat", 64'(lat), 64'd35);
    issue(SDIV, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    result("sdiv_ovf", 32'd0, 32'h8000_0000, 1'b0);
    issue(SDIV, 32'd7, 32'hFFFF_FFFE, 0);
    result("sdiv_7_m2", 32'd1, 32'hFFFF_FFFD, 1'b0);
    issue(SDIV, 32'hFFFF_FFF8, 32'd2, 0);
    result("sdiv_zero_rem", 32'd0, 32'hFFFF_FFFC, 1'b0);

    issue(UDIV, 32'd100, 32'd0, 0);
    result("udiv_by0", 32'd100, 32'd0, 1'b1);
    check("udiv_by0_lat", 64'(lat), 64'd2);
    issue(UDIV, 32'd100, 32'd7, 0);
    result("udiv_100_7", 32'd2, 32'd14, 1'b0);
    issue(SDIV, 32'hFFFF_FFF9, 32'd0, 0);
    result("sdiv_by0_raw", 32'hFFFF_FFF9, 32'd0, 1'b1);

    issue(UDIV, 32'd1000, 32'd10, 5);
    result("start_ignored", 32'd0, 32'd100, 1'b0);
    @(posedge clk); #1;
    check("idle_after_ignored", 64'(Busy), 64'd0);

    issue(UDIV, 32'd100, 32'd7, 0);
    issue(UMULL, 32'd7, 32'd6, 0);
    result("back_to_back", 32'd0, 32'd42, 1'b0);

    issue(UMULL, 32'h1234_5678, 32'h0000_0003, 0);
    result("umull_small", 32'd0, 32'h369D_0368, 1'b0);
`ifdef MULDIV_EARLY_TERM_EN
    check("early_lat_le5", 64'(lat <= 5), 64'd1);
`else
    check("fixed_lat", 64'(lat), 64'd35);
`endif

    @(posedge clk); #1;
    Op = UMULL; SrcA = '1; SrcB = '1; Start = 1'b1;
    @(posedge clk); #1;
    Start = 1'b0;
    repeat (10) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("abort_out", {29'd0, Busy, Done, DivByZero, ResultHi, ResultLo}, 64'd0);
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      seen |= Done | Busy;
    end
    check("abort_no_done", 64'(seen), 64'd0);

    issue(UDIV, 32'd100, 32'd7, 0);
    result("after_abort", 32'd2, 32'd14, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
